// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl -- sequential shift-add unsigned multiplier with HI/LO
// registers and the MFHI/MFLO read path.
//
// A MULTU accepted in IDLE takes 32 RUN cycles (one partial product per
// cycle) plus one DONE cycle, after which the product is committed to HI/LO.
// Any MULTU/MFHI/MFLO arriving while a multiply is in flight is stalled and
// is served in the first IDLE cycle, so reads there see the new HI/LO.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   Signal         funct field of the current instruction
//   valid          Signal/dataA/dataB meaningful this cycle
//   dataA, dataB   multiplicand (rs), multiplier (rt)
//   stall          pipeline must hold the current instruction
//   busy           multiply in progress (state != IDLE)
//   done           one-cycle pulse; HI/LO update on the coming edge
//   hilo_out       MFHI/MFLO read data (0 when rd_valid is low)
//   rd_valid       hilo_out valid for the current MFHI/MFLO
//   hi, lo         architectural HI/LO contents
module mult_hilo_ctrl #(
   parameter logic [5:0] MULTU = 6'b011001,
   parameter logic [5:0] MFHI  = 6'b010000,
   parameter logic [5:0] MFLO  = 6'b010010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  Signal,
   input  logic        valid,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] hilo_out,
   output logic        rd_valid,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  count_q;
   logic [63:0] mcand_q;
   logic [31:0] mplier_q;
   logic [63:0] product_q;
   logic        start;
   logic        is_mul, is_rd;

   assign is_mul = (Signal == MULTU);
   assign is_rd  = (Signal == MFHI) || (Signal == MFLO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      start    = 1'b0;
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
      stall    = 1'b0;
      rd_valid = 1'b0;
      hilo_out = 32'b0;
      case (state_q)
         IDLE: begin
            if (valid && is_mul) begin
               start   = 1'b1;
               state_d = RUN;
            end
            // rst_n gate keeps the read port quiet while reset is held.
            if (rst_n && valid && is_rd) begin
               rd_valid = 1'b1;
               hilo_out = (Signal == MFHI) ? hi : lo;
            end
         end
         RUN: begin
            if (count_q == 5'd31) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (busy && valid && (is_mul || is_rd)) stall = 1'b1;
   end

   // Datapath: operands are captured once at acceptance, so the input
   // buses are free to change while RUN iterates on the private copies.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= 5'd0;
         mcand_q   <= 64'b0;
         mplier_q  <= 32'b0;
         product_q <= 64'b0;
         hi        <= 32'b0;
         lo        <= 32'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q   <= {32'b0, dataA};
                  mplier_q  <= dataB;
                  product_q <= 64'b0;
                  count_q   <= 5'd0;
               end
            end
            RUN: begin
               if (mplier_q[0]) product_q <= product_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + 5'd1;
            end
            DONE: begin
               hi <= product_q[63:32];
               lo <= product_q[31:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl. Inputs change on the falling edge;
// outputs are sampled 1-2 time units after the falling edge.
module tb_mult_hilo_ctrl;

   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   logic        clk, rst_n, valid;
   logic [5:0]  Signal;
   logic [31:0] dataA, dataB;
   logic        stall, busy, done, rd_valid;
   logic [31:0] hilo_out, hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   mult_hilo_ctrl dut (
      .clk(clk), .rst_n(rst_n), .Signal(Signal), .valid(valid),
      .dataA(dataA), .dataB(dataB), .stall(stall), .busy(busy),
      .done(done), .hilo_out(hilo_out), .rd_valid(rd_valid),
      .hi(hi), .lo(lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Called at a falling edge; samples each cycle until busy drops (bounded
   // at 40 cycles). Returns busy-cycle and done-pulse counts; leaves time at
   // falling edge + 1 of the first idle cycle.
   task automatic wait_idle(output int nbusy, output int ndone);
      nbusy = 0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (done === 1'b1) ndone++;
         if (busy !== 1'b1) break;
         nbusy++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; valid = 1'b0; Signal = 6'b0; dataA = 32'b0; dataB = 32'b0;
      #3;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
      n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
      n_checks++; if (done !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_done_rd: got %b/%b want 0/0", done, rd_valid); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_max;
      int nb, nd;
      @(negedge clk);
      valid = 1'b1; Signal = F_MULTU; dataA = 32'hFFFFFFFF; dataB = 32'hFFFFFFFF;
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL max_idle_stall: got %b want 0", stall); end
      @(negedge clk);
      valid = 1'b0;
      wait_idle(nb, nd);
      n_checks++; if (nb != 33) begin n_fail++; $display("FAIL max_busy_cycles: got %0d want 33", nb); end
      n_checks++; if (nd != 1) begin n_fail++; $display("FAIL max_done_pulses: got %0d want 1", nd); end
      n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL max_hi: got %h want fffffffe", hi); end
      n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL max_lo: got %h want 00000001", lo); end
      valid = 1'b1; Signal = F_MFHI;
      #1;
      n_checks++; if (hilo_out !== 32'hFFFFFFFE || rd_valid !== 1'b1) begin n_fail++; $display("FAIL mfhi_read: got %h/%b want fffffffe/1", hilo_out, rd_valid); end
      Signal = F_MFLO;
      #1;
      n_checks++; if (hilo_out !== 32'h00000001 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL mflo_read: got %h/%b want 00000001/1", hilo_out, rd_valid); end
      valid = 1'b0;
   endtask

   task automatic test_stall_read;
      int ns;
      ns = 0;
      @(negedge clk);
      valid = 1'b1; Signal = F_MULTU; dataA = 32'd3; dataB = 32'd5;
      @(negedge clk);
      Signal = F_MFLO; dataA = 32'hDEADBEEF; dataB = 32'h12345678;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (stall !== 1'b1) break;
         ns++;
         @(negedge clk);
      end
      n_checks++; if (ns != 33) begin n_fail++; $display("FAIL stall_cycles: got %0d want 33", ns); end
      n_checks++; if (hilo_out !== 32'h0000000F) begin n_fail++; $display("FAIL stalled_mflo_data: got %h want 0000000f", hilo_out); end
      n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL stalled_mflo_rdv: got %b want 1", rd_valid); end
      n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL small_hi: got %h want 0", hi); end
      valid = 1'b0;
   endtask

   task automatic test_reset_abort;
      int nb, nd;
      @(negedge clk);
      valid = 1'b1; Signal = F_MULTU; dataA = 32'd7; dataB = 32'd9;
      @(negedge clk);
      valid = 1'b0;
      repeat (9) @(negedge clk);
      #2;
      rst_n = 1'b0; valid = 1'b1; Signal = F_MFHI;
      #1;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_busy_done: got %b/%b want 0/0", busy, done); end
      n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL abort_hilo: got %h/%h want 0/0", hi, lo); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall: got %b want 0", stall); end
      n_checks++; if (rd_valid !== 1'b0 || hilo_out !== 32'h0) begin n_fail++; $display("FAIL abort_read: got %b/%h want 0/0", rd_valid, hilo_out); end
      @(negedge clk);
      rst_n = 1'b1; Signal = F_MULTU; dataA = 32'd2; dataB = 32'd2;
      @(negedge clk);
      valid = 1'b0;
      wait_idle(nb, nd);
      n_checks++; if (nb != 33) begin n_fail++; $display("FAIL post_reset_busy: got %0d want 33", nb); end
      n_checks++; if (nd != 1) begin n_fail++; $display("FAIL post_reset_done: got %0d want 1", nd); end
      n_checks++; if (lo !== 32'd4 || hi !== 32'd0) begin n_fail++; $display("FAIL post_reset_result: got %h/%h want 0/4", hi, lo); end
   endtask

   task automatic test_back_to_back;
      int ns, nb, nd;
      ns = 0;
      @(negedge clk);
      valid = 1'b1; Signal = F_MULTU; dataA = 32'd6; dataB = 32'd7;
      @(negedge clk);
      dataA = 32'hAAAA5555; dataB = 32'h5555AAAA;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (stall !== 1'b1) break;
         ns++;
         dataA = ~dataA; dataB = ~dataB;
         @(negedge clk);
      end
      n_checks++; if (ns != 33) begin n_fail++; $display("FAIL b2b_stall: got %0d want 33", ns); end
      n_checks++; if (hi !== 32'd0 || lo !== 32'd42) begin n_fail++; $display("FAIL b2b_first: got %h/%h want 0/2a", hi, lo); end
      dataA = 32'd100; dataB = 32'd3;
      @(negedge clk);
      valid = 1'b0;
      wait_idle(nb, nd);
      n_checks++; if (nb != 33) begin n_fail++; $display("FAIL b2b_second_busy: got %0d want 33", nb); end
      n_checks++; if (hi !== 32'd0 || lo !== 32'd300) begin n_fail++; $display("FAIL b2b_second: got %h/%h want 0/12c", hi, lo); end
   endtask

   task automatic test_zero_sll;
      int nb, nd;
      @(negedge clk);
      valid = 1'b1; Signal = F_MULTU; dataA = 32'd0; dataB = 32'h12345678;
      @(negedge clk);
      valid = 1'b0;
      wait_idle(nb, nd);
      n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL zero_result: got %h/%h want 0/0", hi, lo); end
      valid = 1'b1; Signal = 6'b000000; dataA = 32'd5; dataB = 32'd5;
      #1;
      n_checks++; if (stall !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL sll_stall_busy: got %b/%b want 0/0", stall, busy); end
      n_checks++; if (rd_valid !== 1'b0 || hilo_out !== 32'h0) begin n_fail++; $display("FAIL sll_read: got %b/%h want 0/0", rd_valid, hilo_out); end
      @(negedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sll_no_start: got %b want 0", busy); end
      valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_max();
      test_stall_read();
      test_reset_abort();
      test_back_to_back();
      test_zero_sll();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
